// File: rtl/sync_fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for sync_fifo_write_arbiter.
// The master modport is the environment: producers, the consumer strobe and the status observers.
// The slave modport is the arbiter itself.
interface sync_fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_write_enable;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_read_enable;
  logic [ID_W-1:0]               grant_id;
  logic [DEPTH_BITS:0]           occupancy;
  logic                          full;
  logic                          empty;
  logic                          underrun_seen;

  modport master (
    output req_valid, req_data, fifo_read_enable,
    input  req_ready, fifo_write_enable, fifo_data_in, grant_id,
           occupancy, full, empty, underrun_seen
  );

  modport slave (
    input  req_valid, req_data, fifo_read_enable,
    output req_ready, fifo_write_enable, fifo_data_in, grant_id,
           occupancy, full, empty, underrun_seen
  );
endinterface

// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin arbiter sharing the single write port of a sync FIFO among NUM_REQ producers.
// A local occupancy count replaces the missing FIFO full flag, so no write can overrun the FIFO.
// Optional burst mode: define SYNC_FIFO_ARB_BURST_EN to let a winner keep the grant for up to
// MAX_BURST consecutive beats (ARB_HOLD state). Without the macro the grant rotates every beat.
module sync_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  sync_fifo_write_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [DEPTH_BITS:0] CAP = (DEPTH_BITS + 1)'((1 << DEPTH_BITS) - 1);

`ifdef SYNC_FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [0:0] {ARB_IDLE, ARB_HOLD} arb_state_t;

  arb_state_t          state, state_next;
  logic [BEAT_W-1:0]   beat_count, beat_next;
  logic [ID_W-1:0]     rr_ptr, grant_id, winner, idx;
  logic [NUM_REQ-1:0]  ready;
  logic                found, can_accept;
  logic                write_enable, underrun_seen, full, empty;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DEPTH_BITS:0] occupancy, occ_next;

  // Conservative space check: a write already in flight counts as occupied, a same-cycle read does not.
  assign can_accept = (occupancy + (DEPTH_BITS + 1)'(write_enable)) < CAP;

  // Pick a winner (held producer in ARB_HOLD, round-robin search otherwise) and compute the next FSM state.
  always_comb begin
    ready      = '0;
    found      = 1'b0;
    winner     = '0;
    idx        = '0;
    state_next = state;
    beat_next  = beat_count;
    if (reset_n && can_accept) begin
      if (state == ARB_HOLD) begin
        if (bus.req_valid[grant_id]) begin
          found  = 1'b1;
          winner = grant_id;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
          if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
          end
        end
      end
    end
    if (found) ready[winner] = 1'b1;
    case (state)
      ARB_IDLE: begin
        if (BURST_EN && found && MAX_BURST > 1) begin
          state_next = ARB_HOLD;
          beat_next  = BEAT_W'(1);
        end
      end
      ARB_HOLD: begin
        if (!found || (int'(beat_count) + 1) >= MAX_BURST) begin
          state_next = ARB_IDLE;
          beat_next  = '0;
        end else begin
          beat_next = beat_count + 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Next occupancy: a registered write adds a word, a read removes one only if a word is held.
  always_comb begin
    occ_next = occupancy;
    if (write_enable && !(bus.fifo_read_enable && occupancy != '0))
      occ_next = occupancy + 1'b1;
    else if (!write_enable && bus.fifo_read_enable && occupancy != '0)
      occ_next = occupancy - 1'b1;
  end

  // Registered write port, grant bookkeeping, occupancy flags and FSM state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      beat_count    <= '0;
      rr_ptr        <= '0;
      grant_id      <= '0;
      write_enable  <= 1'b0;
      data_in       <= '0;
      occupancy     <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      underrun_seen <= 1'b0;
    end else begin
      state        <= state_next;
      beat_count   <= beat_next;
      write_enable <= found;
      if (found) begin
        data_in  <= bus.req_data[int'(winner) * DATA_WIDTH +: DATA_WIDTH];
        grant_id <= winner;
        rr_ptr   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      occupancy <= occ_next;
      full      <= (occ_next == CAP);
      empty     <= (occ_next == '0);
      if (bus.fifo_read_enable && occupancy == '0) underrun_seen <= 1'b1;
    end
  end

  assign bus.req_ready         = ready;
  assign bus.fifo_write_enable = write_enable;
  assign bus.fifo_data_in      = data_in;
  assign bus.grant_id          = grant_id;
  assign bus.occupancy         = occupancy;
  assign bus.full              = full;
  assign bus.empty             = empty;
  assign bus.underrun_seen     = underrun_seen;
endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Directed bench for sync_fifo_write_arbiter with NUM_REQ=4, DEPTH_BITS=2 (CAP=3), MAX_BURST=2.
// Expected grant order in the two-producer scenario depends on SYNC_FIFO_ARB_BURST_EN.
module tb_sync_fifo_write_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH_BITS = 2;
  localparam int MAX_BURST  = 2;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  sync_fifo_write_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH_BITS(DEPTH_BITS)
  ) bus ();

  sync_fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH_BITS(DEPTH_BITS), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge and let registered outputs settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Quiet the inputs and hold reset for two cycles.
  task automatic apply_reset();
    bus.req_valid        = '0;
    bus.req_data         = '0;
    bus.fifo_read_enable = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n              = 1'b0;
    bus.req_valid        = 4'b1111;
    bus.req_data         = 32'h13121110;
    bus.fifo_read_enable = 1'b0;
    step();
    step();
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0000", bus.req_ready); end
    total++;
    if (bus.fifo_write_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", bus.fifo_write_enable); end
    total++;
    if (bus.fifo_data_in !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", bus.fifo_data_in); end
    total++;
    if (bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant got=%0d want=0", bus.grant_id); end
    total++;
    if (bus.occupancy !== 3'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d want=0", bus.occupancy); end
    total++;
    if (bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.underrun_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got full=%b empty=%b underrun=%b want 0 1 0", bus.full, bus.empty, bus.underrun_seen);
    end
    bus.req_valid = '0;
    reset_n = 1'b1;
  endtask

  // All four producers valid, consumer reading every cycle: strict rotation 0,1,2,3,0...
  task automatic test_round_robin();
    logic [3:0] exp_ready;
    apply_reset();
    bus.req_data         = 32'hA3A2A1A0;
    bus.req_valid        = 4'b1111;
    bus.fifo_read_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_ready = 4'b0001 << (k % 4);
      total++;
      if (bus.req_ready !== exp_ready) begin bad++; $display("[TB] FAIL rr_ready[%0d] got=%b want=%b", k, bus.req_ready, exp_ready); end
      step();
      total++;
      if (bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== 8'hA0 + 8'(k % 4)) begin
        bad++;
        $display("[TB] FAIL rr_write[%0d] got we=%b data=%h want we=1 data=%h", k, bus.fifo_write_enable, bus.fifo_data_in, 8'hA0 + 8'(k % 4));
      end
      total++;
      if (bus.grant_id !== 2'(k % 4)) begin bad++; $display("[TB] FAIL rr_grant[%0d] got=%0d want=%0d", k, bus.grant_id, k % 4); end
    end
    bus.req_valid = '0;
    step();
    total++;
    if (bus.fifo_write_enable !== 1'b0) begin bad++; $display("[TB] FAIL rr_idle_we got=%b want=0", bus.fifo_write_enable); end
    bus.fifo_read_enable = 1'b0;
  endtask

  // Only producer 2, no reads: exactly three writes fill CAP=3, then the grant is withheld.
  task automatic test_fill();
    logic [3:0] exp_ready;
    logic       exp_we;
    logic [2:0] exp_occ;
    apply_reset();
    bus.req_data  = 32'h005C0000;
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ready = (k < 3) ? 4'b0100 : 4'b0000;
      exp_we    = (k < 3);
      exp_occ   = (k < 3) ? 3'(k) : 3'd3;
      total++;
      if (bus.req_ready !== exp_ready) begin bad++; $display("[TB] FAIL fill_ready[%0d] got=%b want=%b", k, bus.req_ready, exp_ready); end
      step();
      total++;
      if (bus.fifo_write_enable !== exp_we) begin bad++; $display("[TB] FAIL fill_we[%0d] got=%b want=%b", k, bus.fifo_write_enable, exp_we); end
      total++;
      if (bus.occupancy !== exp_occ) begin bad++; $display("[TB] FAIL fill_occ[%0d] got=%0d want=%0d", k, bus.occupancy, exp_occ); end
    end
    total++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0 || bus.grant_id !== 2'd2) begin
      bad++;
      $display("[TB] FAIL fill_flags got full=%b empty=%b grant=%0d want 1 0 2", bus.full, bus.empty, bus.grant_id);
    end
  endtask

  // From full: one read frees a slot, one new accept, then a read alongside the write keeps occupancy at 2.
  task automatic test_read_frees_slot();
    bus.fifo_read_enable = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL free_ready_full got=%b want=0000", bus.req_ready); end
    step();
    total++;
    if (bus.occupancy !== 3'd2 || bus.full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL free_occ got occ=%0d full=%b want occ=2 full=0", bus.occupancy, bus.full);
    end
    bus.fifo_read_enable = 1'b0;
    bus.req_data = 32'h00770000;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL free_ready got=%b want=0100", bus.req_ready); end
    step();
    total++;
    if (bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== 8'h77) begin
      bad++;
      $display("[TB] FAIL free_write got we=%b data=%h want we=1 data=77", bus.fifo_write_enable, bus.fifo_data_in);
    end
    bus.fifo_read_enable = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL free_inflight_ready got=%b want=0000", bus.req_ready); end
    step();
    total++;
    if (bus.occupancy !== 3'd2 || bus.fifo_write_enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL free_rw_occ got occ=%0d we=%b want occ=2 we=0", bus.occupancy, bus.fifo_write_enable);
    end
    bus.fifo_read_enable = 1'b0;
    bus.req_valid = '0;
  endtask

  // Read on an empty FIFO: occupancy stays 0 and underrun_seen sticks until reset.
  task automatic test_underrun();
    apply_reset();
    bus.fifo_read_enable = 1'b1;
    step();
    bus.fifo_read_enable = 1'b0;
    total++;
    if (bus.occupancy !== 3'd0 || bus.empty !== 1'b1 || bus.underrun_seen !== 1'b1) begin
      bad++;
      $display("[TB] FAIL underrun_set got occ=%0d empty=%b underrun=%b want 0 1 1", bus.occupancy, bus.empty, bus.underrun_seen);
    end
    step();
    step();
    total++;
    if (bus.underrun_seen !== 1'b1) begin bad++; $display("[TB] FAIL underrun_sticky got=%b want=1", bus.underrun_seen); end
    reset_n = 1'b0;
    step();
    total++;
    if (bus.underrun_seen !== 1'b0) begin bad++; $display("[TB] FAIL underrun_clear got=%b want=0", bus.underrun_seen); end
    reset_n = 1'b1;
  endtask

  // Reset right after an accept drops the pending write and restarts the rotation at producer 0.
  task automatic test_reset_mid();
    apply_reset();
    bus.req_data  = 32'hD3D2D1D0;
    bus.req_valid = 4'b1111;
    step();
    total++;
    if (bus.fifo_write_enable !== 1'b1 || bus.grant_id !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_accept got we=%b grant=%0d want we=1 grant=0", bus.fifo_write_enable, bus.grant_id);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_ready_in_reset got=%b want=0000", bus.req_ready); end
    step();
    total++;
    if (bus.fifo_write_enable !== 1'b0 || bus.occupancy !== 3'd0) begin
      bad++;
      $display("[TB] FAIL mid_dropped got we=%b occ=%0d want we=0 occ=0", bus.fifo_write_enable, bus.occupancy);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL mid_rr_restart got=%b want=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  // Producers 0 and 1 valid, reads every cycle: burst build gives 0,0,1,1,0,0, rotation gives 0,1,0,1,0,1.
  task automatic test_two_producers();
    logic [1:0] exp_order [6];
`ifdef SYNC_FIFO_ARB_BURST_EN
    exp_order = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
`else
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
    apply_reset();
    bus.req_data         = 32'h00001110;
    bus.req_valid        = 4'b0011;
    bus.fifo_read_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (bus.grant_id !== exp_order[k] || bus.fifo_data_in !== 8'h10 + 8'(exp_order[k])) begin
        bad++;
        $display("[TB] FAIL order[%0d] got grant=%0d data=%h want grant=%0d", k, bus.grant_id, bus.fifo_data_in, exp_order[k]);
      end
    end
    bus.req_valid        = '0;
    bus.fifo_read_enable = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    total = 0;
    bad   = 0;
    reset_n              = 1'b0;
    bus.req_valid        = '0;
    bus.req_data         = '0;
    bus.fifo_read_enable = 1'b0;
    test_reset();
    test_round_robin();
    test_fill();
    test_read_frees_slot();
    test_underrun();
    test_reset_mid();
    test_two_producers();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
